// File: rtl/instr_fetch_pkg.sv
// mips_cpu_pkg: fetch FSM state type and fixed addresses
// shared by the instruction fetch block and its bench
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: Avalon-MM read bus (address/read/byteenable
// out of the master, waitrequest/readdata back from the slave)
interface instr_fetch_if;

  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output byteenable,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  byteenable,
    output waitrequest,
    output readdata
  );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: one Avalon read per fetch_en, optional byte swap,
// flush/timeout handling. Ports: clk, reset(n), pc, fetch_en,
// flush, bus(master), instr, instr_valid, updatePC, active, fault
import mips_cpu_pkg::*;

module instr_fetch #(
  parameter int BYTE_SWAP  = 1,
  parameter int WAIT_LIMIT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  input  logic          fetch_en,
  input  logic          flush,
  instr_fetch_if.master bus,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          updatePC,
  output logic          active,
  output logic          fault
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_addr, w_addr_nxt;
  logic         r_read, w_read_nxt;
  logic [3:0]   r_be, w_be_nxt;
  logic [31:0]  r_instr, w_instr_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_fault, w_fault_nxt;
  logic [7:0]   r_wcnt, w_wcnt_nxt;
  logic         r_flushed, w_flushed_nxt;
  logic [7:0]   w_wcnt_inc;
  logic [31:0]  w_rdata;
  logic         w_drop;

  assign w_wcnt_inc = r_wcnt + 8'd1;

  assign w_rdata = (BYTE_SWAP != 0) ?
    {bus.readdata[7:0],   bus.readdata[15:8],
     bus.readdata[23:16], bus.readdata[31:24]} :
    bus.readdata;

  // flush may arrive in any REQ cycle, so remember it
  assign w_drop = r_flushed | flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_read    <= 1'b0;
      r_be      <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_wcnt    <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_read    <= w_read_nxt;
      r_be      <= w_be_nxt;
      r_instr   <= w_instr_nxt;
      r_valid   <= w_valid_nxt;
      r_fault   <= w_fault_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_flushed <= w_flushed_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_read_nxt    = r_read;
    w_be_nxt      = r_be;
    w_instr_nxt   = r_instr;
    w_valid_nxt   = 1'b0;
    w_fault_nxt   = r_fault;
    w_wcnt_nxt    = r_wcnt;
    w_flushed_nxt = r_flushed;
    unique case (r_state)
      IDLE: begin
        if (fetch_en) begin
          unique case (1'b1)
            (pc == HALT_ADDR): begin
              w_state_nxt = HALTED;
            end
            (pc[1:0] != 2'b00): begin
              w_state_nxt = HALTED;
              w_fault_nxt = 1'b1;
            end
            default: begin
              w_state_nxt   = REQ;
              w_addr_nxt    = pc;
              w_read_nxt    = 1'b1;
              w_be_nxt      = 4'hF;
              w_wcnt_nxt    = '0;
              w_flushed_nxt = 1'b0;
            end
          endcase
        end
      end
      REQ: begin
        if (!bus.waitrequest) begin
          w_state_nxt = IDLE;
          w_read_nxt  = 1'b0;
          w_be_nxt    = '0;
          if (!w_drop) begin
            w_instr_nxt = w_rdata;
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_flushed_nxt = w_drop;
          w_wcnt_nxt    = w_wcnt_inc;
          if (WAIT_LIMIT != 0 && w_wcnt_inc == LIMIT) begin
            w_state_nxt = HALTED;
            w_fault_nxt = 1'b1;
            w_read_nxt  = 1'b0;
            w_be_nxt    = '0;
          end
        end
      end
      HALTED: begin
        w_read_nxt = 1'b0;
        w_be_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.address    = r_addr;
  assign bus.read       = r_read;
  assign bus.byteenable = r_be;
  assign instr          = r_instr;
  assign instr_valid    = r_valid;
  assign updatePC       = r_valid;
  assign fault          = r_fault;
  assign active         = (r_state != HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + random fetches against a
// transaction-level model; two instances (default, no-swap/limit 4)
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_s [2];
  logic        fe [2];
  logic        fl_s [2];
  logic        wr [2];
  logic [31:0] rd [2];

  logic [31:0] addr_o [2];
  logic        read_o [2];
  logic [3:0]  be_o [2];
  logic [31:0] instr_o [2];
  logic        iv_o [2];
  logic        up_o [2];
  logic        act_o [2];
  logic        flt_o [2];

  logic [31:0] m_instr [2];
  int n_chk = 0;
  int n_pass = 0;

  instr_fetch_if bus_a ();
  instr_fetch_if bus_b ();

  assign bus_a.waitrequest = wr[0];
  assign bus_a.readdata    = rd[0];
  assign bus_b.waitrequest = wr[1];
  assign bus_b.readdata    = rd[1];
  assign addr_o[0] = bus_a.address;
  assign read_o[0] = bus_a.read;
  assign be_o[0]   = bus_a.byteenable;
  assign addr_o[1] = bus_b.address;
  assign read_o[1] = bus_b.read;
  assign be_o[1]   = bus_b.byteenable;

  instr_fetch u_a (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc_s[0]),
    .fetch_en    (fe[0]),
    .flush       (fl_s[0]),
    .bus         (bus_a),
    .instr       (instr_o[0]),
    .instr_valid (iv_o[0]),
    .updatePC    (up_o[0]),
    .active      (act_o[0]),
    .fault       (flt_o[0])
  );

  instr_fetch #(.BYTE_SWAP(0), .WAIT_LIMIT(4)) u_b (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc_s[1]),
    .fetch_en    (fe[1]),
    .flush       (fl_s[1]),
    .bus         (bus_b),
    .instr       (instr_o[1]),
    .instr_valid (iv_o[1]),
    .updatePC    (up_o[1]),
    .active      (act_o[1]),
    .fault       (flt_o[1])
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    for (int s = 0; s < 2; s++) begin
      chk({tag, "_addr"},  addr_o[s],  32'h0);
      chk({tag, "_read"},  read_o[s],  32'h0);
      chk({tag, "_be"},    be_o[s],    32'h0);
      chk({tag, "_instr"}, instr_o[s], 32'h0);
      chk({tag, "_iv"},    iv_o[s],    32'h0);
      chk({tag, "_upd"},   up_o[s],    32'h0);
      chk({tag, "_flt"},   flt_o[s],   32'h0);
      chk({tag, "_act"},   act_o[s],   32'h1);
    end
  endtask

  // One fetch: waits stall cycles, flush in REQ cycle flc (-1 none).
  // Entered just after a falling edge with the DUT in IDLE.
  task automatic fetch(input int s, input logic [31:0] p,
                       input logic [31:0] d, input int waits,
                       input int flc);
    pc_s[s] = p;
    fe[s]   = 1'b1;
    wr[s]   = 1'b0;
    fl_s[s] = 1'($urandom);
    @(negedge clk);
    fe[s]   = 1'b0;
    pc_s[s] = $urandom;
    for (int i = 0; i <= waits; i++) begin
      chk("req_read", read_o[s], 32'h1);
      chk("req_addr", addr_o[s], p);
      chk("req_be",   be_o[s],   32'hF);
      chk("req_iv",   iv_o[s],   32'h0);
      fe[s]   = 1'($urandom);
      wr[s]   = (i < waits);
      rd[s]   = (i < waits) ? $urandom : d;
      fl_s[s] = (i == flc);
      @(negedge clk);
    end
    fe[s]   = 1'b0;
    wr[s]   = 1'b0;
    fl_s[s] = 1'($urandom);
    if (flc < 0) m_instr[s] = (s == 0) ? swap(d) : d;
    chk("done_read",  read_o[s],  32'h0);
    chk("done_be",    be_o[s],    32'h0);
    chk("done_iv",    iv_o[s],    (flc < 0) ? 32'h1 : 32'h0);
    chk("done_upd",   up_o[s],    (flc < 0) ? 32'h1 : 32'h0);
    chk("done_instr", instr_o[s], m_instr[s]);
    @(negedge clk);
    fl_s[s] = 1'b0;
    chk("idle_iv",    iv_o[s],    32'h0);
    chk("idle_read",  read_o[s],  32'h0);
    chk("idle_instr", instr_o[s], m_instr[s]);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      pc_s[s] = '0; fe[s] = 0; fl_s[s] = 0;
      wr[s] = 0; rd[s] = '0; m_instr[s] = '0;
    end
    #1 reset = 1'b0;
    #1 chk_reset("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fetch(0, 32'hBFC0_0000, 32'h3C08_1234, 0, -1);
    chk("swap_const", instr_o[0], 32'h3412_083C);

    fetch(0, 32'hBFC0_0004, 32'h2408_0001, 3, -1);
    fetch(0, 32'hBFC0_0008, 32'hDEAD_BEEF, 2, 1);
    chk("flush_keep", instr_o[0], 32'h0100_0824);
    fetch(0, 32'hBFC0_000C, 32'h1234_5678, 1, 1);

    for (int k = 0; k < 25; k++) begin
      automatic int w  = int'($urandom_range(0, 4));
      automatic int fc = ($urandom_range(0, 3) == 0) ?
                         int'($urandom_range(0, w)) : -1;
      automatic logic [31:0] p = ($urandom & 32'hFFFF_FFFC)
                                 | 32'h4;
      fetch(0, p, $urandom, w, fc);
    end

    pc_s[0] = 32'h0000_1000;
    fe[0]   = 1'b1;
    @(negedge clk);
    fe[0] = 1'b0;
    wr[0] = 1'b1;
    chk("mid_read", read_o[0], 32'h1);
    #3 reset = 1'b0;
    #1 m_instr[0] = '0;
    chk_reset("midrst");
    @(negedge clk);
    wr[0] = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_iv",   iv_o[0],   32'h0);
      chk("post_read", read_o[0], 32'h0);
      chk("post_act",  act_o[0],  32'h1);
    end

    pc_s[0] = 32'h0;
    fe[0]   = 1'b1;
    @(negedge clk);
    chk("h0_act",  act_o[0],  32'h0);
    chk("h0_flt",  flt_o[0],  32'h0);
    chk("h0_read", read_o[0], 32'h0);
    pc_s[0] = 32'h0000_2000;
    fl_s[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hs_act",  act_o[0],  32'h0);
      chk("hs_read", read_o[0], 32'h0);
      chk("hs_iv",   iv_o[0],   32'h0);
    end
    fe[0] = 1'b0;
    fl_s[0] = 1'b0;
    reset = 1'b0;
    #1 chk("hr_act", act_o[0], 32'h1);
    @(negedge clk);
    reset = 1'b1;
    pc_s[0] = 32'hBFC0_0002;
    fe[0]   = 1'b1;
    @(negedge clk);
    fe[0] = 1'b0;
    chk("mis_flt",  flt_o[0],  32'h1);
    chk("mis_act",  act_o[0],  32'h0);
    chk("mis_read", read_o[0], 32'h0);
    @(negedge clk);
    chk("mis_stick", flt_o[0], 32'h1);

    fetch(1, 32'h2000_0040, 32'h3C08_1234, 3, -1);
    chk("b_noswap", instr_o[1], 32'h3C08_1234);
    chk("b_noflt",  flt_o[1],   32'h0);

    pc_s[1] = 32'h2000_0044;
    fe[1]   = 1'b1;
    @(negedge clk);
    fe[1] = 1'b0;
    wr[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("to_read", read_o[1], 32'h1);
      chk("to_addr", addr_o[1], 32'h2000_0044);
      chk("to_flt",  flt_o[1],  32'h0);
      @(negedge clk);
    end
    chk("to_drop", read_o[1], 32'h0);
    chk("to_fault", flt_o[1], 32'h1);
    chk("to_act",  act_o[1],  32'h0);
    chk("to_iv",   iv_o[1],   32'h0);
    wr[1] = 1'b0;
    @(negedge clk);
    chk("to_stick", act_o[1], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
